mdu_hilo: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers; execute-stage consumer of the register file's rs/rt read data.

---
 rtl/mdu_hilo_pkg.sv | 31 +++
 rtl/mdu_hilo_if.sv | 30 +++
 rtl/mdu_step.sv | 34 +++
 rtl/mdu_hilo.sv | 118 +++++++++++
 tb/tb_mdu_hilo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared widths, op and state encodings for the HI/LO MDU.
// Ports: none (package).
package mdu_hilo_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = XLEN;
  localparam int CNTW  = $clog2(ITERS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  // Two's-complement magnitude; 0x8000_0000 maps to itself,
  // which reads correctly as an unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] v,
    input logic            neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: start/busy/done and MTHI/MTLO bus between EX control and MDU.
// master drives start/op/rs_data/rt_data/hi_we/lo_we/wdata; slave returns busy/done/hi_out/lo_out.
interface mdu_hilo_if;
  import mdu_hilo_pkg::*;

  logic            start;
  op_e             op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;

  modport master (
    output start, op, rs_data, rt_data,
    output hi_we, lo_we, wdata,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    input  hi_we, lo_we, wdata,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational shift-add (mul) or restoring (div) iteration.
// Ports: acc/ql/opb/is_div in; acc_n/ql_n out (next {acc, mplr-or-quotient}).
module mdu_step
  import mdu_hilo_pkg::*;
(
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] ql,
  input  logic [XLEN-1:0] opb,
  input  logic            is_div,
  output logic [XLEN-1:0] acc_n,
  output logic [XLEN-1:0] ql_n
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum  = {1'b0, acc} + (ql[0] ? {1'b0, opb} : '0);
    shl  = {acc, ql[XLEN-1]};
    ge   = shl >= {1'b0, opb};
    // remainder stays below divisor, so 32 bits of the difference suffice
    diff = shl[XLEN-1:0] - opb;
    if (is_div) begin
      acc_n = ge ? diff : shl[XLEN-1:0];
      ql_n  = {ql[XLEN-2:0], ge};
    end else begin
      acc_n = sum[XLEN:1];
      ql_n  = {sum[0], ql[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, 34-cycle op latency.
// Ports: clk, rst (sync, active-high), bus (mdu_hilo_if.slave).
module mdu_hilo
  import mdu_hilo_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  state_e            state;
  op_e               op_q;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   ql;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              neg_q;
  logic              neg_r;
  logic              div0;
  logic              busy_q;
  logic              done_q;

  logic [XLEN-1:0]   acc_n;
  logic [XLEN-1:0]   ql_n;
  logic              is_div;
  logic              sa;
  logic              sb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign is_div = op_q[1];
  assign sa     = ~bus.op[0] & bus.rs_data[XLEN-1];
  assign sb     = ~bus.op[0] & bus.rt_data[XLEN-1];

  mdu_step u_step (
    .acc    (acc),
    .ql     (ql),
    .opb    (opb),
    .is_div (is_div),
    .acc_n  (acc_n),
    .ql_n   (ql_n)
  );

  // With a zero divisor the restoring loop leaves |rs| in acc,
  // so the remainder fix-up already yields rs; only LO is forced.
  always_comb begin
    prod = neg_q ? (~{acc, ql} + 1'b1) : {acc, ql};
    quo  = div0 ? '1 : (neg_q ? (~ql + 1'b1) : ql);
    rem  = neg_r ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      cnt    <= '0;
      acc    <= '0;
      ql     <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            acc    <= '0;
            ql     <= mag(bus.rs_data, sa);
            opb    <= mag(bus.rt_data, sb);
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= bus.op[1] & (bus.rt_data == '0);
            cnt    <= CNTW'(ITERS - 1);
            busy_q <= 1'b1;
            state  <= S_CALC;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          acc <= acc_n;
          ql  <= ql_n;
          if (cnt == '0) state <= S_FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        S_FINISH: begin
          if (is_div) begin
            hi_q <= rem;
            lo_q <= quo;
          end else begin
            hi_q <= prod[2*XLEN-1:XLEN];
            lo_q <= prod[XLEN-1:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed + random checks of mdu_hilo against an arithmetic model.
// Ports: none (top-level bench).
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   fails = 0;
  int   passed;

  always #5 clk = ~clk;

  mdu_hilo_if bus ();

  mdu_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input op_e o, input logic [31:0] a, input logic [31:0] b,
    output logic [31:0] eh, output logic [31:0] el
  );
    longint sa, sb, ua, ub, r, q;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = 0;
    q  = 0;
    case (o)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = ua * ub;
      OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; end
      default:  if (b != 0) begin q = ua / ub; r = ua % ub; end
    endcase
    if (o == OP_MULT || o == OP_MULTU) begin
      eh = r[63:32];
      el = r[31:0];
    end else if (b == 0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input op_e o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el, h0, l0;
    int n;
    model(o, a, b, eh, el);
    h0 = bus.hi_out;
    l0 = bus.lo_out;
    bus.start   = 1'b1;
    bus.op      = o;
    bus.rs_data = a;
    bus.rt_data = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (n == 1) begin
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
      end
      if (n == 17) chk({tag, " hold"}, bus.hi_out ^ bus.lo_out, h0 ^ l0);
    end while (!bus.done && n < 60);
    chk({tag, " latency"}, 32'(n), 32'd34);
    chk({tag, " hi"}, bus.hi_out, eh);
    chk({tag, " lo"}, bus.lo_out, el);
    chk({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, hsave;
    int n, dcount;
    op_e o;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_MULT;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.wdata   = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst hi", bus.hi_out, 32'd0);
    chk("rst lo", bus.lo_out, 32'd0);
    rst = 1'b0;

    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_0001;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mt both hi", bus.hi_out, 32'hA5A5_0001);
    chk("mt both lo", bus.lo_out, 32'hA5A5_0001);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    chk("multu max hi k", bus.hi_out, 32'hFFFF_FFFE);
    chk("multu max lo k", bus.lo_out, 32'h0000_0001);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
    chk("mult -3*7 lo k", bus.lo_out, 32'hFFFF_FFEB);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult min*min");
    chk("mult min hi k", bus.hi_out, 32'h4000_0000);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    chk("div -7/2 hi k", bus.hi_out, 32'hFFFF_FFFF);
    chk("div -7/2 lo k", bus.lo_out, 32'hFFFF_FFFD);
    do_op(OP_DIVU, 32'd100, 32'd7, "divu 100/7");
    chk("divu lo k", bus.lo_out, 32'd14);
    do_op(OP_DIVU, 32'd5, 32'd0, "divu 5/0");
    chk("divu 5/0 hi k", bus.hi_out, 32'd5);
    do_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, "div neg/0");
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    chk("div min lo k", bus.lo_out, 32'h8000_0000);
    chk("div min hi k", bus.hi_out, 32'd0);

    // stray starts and MTHI while busy must be ignored
    @(negedge clk);
    hsave       = bus.hi_out;
    bus.start   = 1'b1;
    bus.op      = OP_MULT;
    bus.rs_data = 32'd1234;
    bus.rt_data = 32'hFFFF_FF00;
    n = 0;
    dcount = 0;
    repeat (45) begin
      @(negedge clk);
      n++;
      bus.start = (n == 5 || n == 20);
      bus.hi_we = (n == 12);
      bus.wdata = 32'hDEAD_BEEF;
      bus.rs_data = $urandom;
      if (n == 13) chk("mthi busy", bus.hi_out, hsave);
      if (bus.done) begin
        dcount++;
        chk("ignore lat", 32'(n), 32'd34);
        chk("ignore hi", bus.hi_out, 32'hFFFF_FFFF);
        chk("ignore lo", bus.lo_out, 32'hFFFB_2E00);
      end
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("single done", 32'(dcount), 32'd1);

    // reset mid-divide aborts with no result
    do_op(OP_MULTU, 32'd3, 32'd3, "pre rst");
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_DIVU;
    bus.rs_data = 32'd100;
    bus.rt_data = 32'd7;
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort hi", bus.hi_out, 32'd0);
    chk("abort lo", bus.lo_out, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("abort nodone", 32'(dcount), 32'd0);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo", bus.lo_out, 32'h1234);
    chk("mtlo hi kept", bus.hi_out, 32'd0);

    // MT* with start=1: start wins, HI/LO untouched until FINISH
    bus.hi_we   = 1'b1;
    bus.wdata   = 32'h5555_5555;
    bus.start   = 1'b1;
    bus.op      = OP_MULTU;
    bus.rs_data = 32'd6;
    bus.rt_data = 32'd7;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.start = 1'b0;
    chk("start wins", bus.hi_out, 32'd0);
    n = 1;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("start wins lo", bus.lo_out, 32'd42);

    // random back-to-back ops, each launched in the previous done cycle
    for (int i = 0; i < 24; i++) begin
      o = op_e'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      if ($urandom_range(0, 2) == 0) a = 32'($signed(-$urandom_range(1, 300)));
      do_op(o, a, b, $sformatf("rnd%0d op%0d", i, o));
    end

    passed = total - fails;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
